// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder and its requesters.
package data_mem_responder_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  localparam int unsigned MEM_BE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mem_rsp_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Valid/ready load/store request and response channel between core and memory.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                req_valid;
  logic                req_ready;
  addr_t               req_addr;
  logic                req_we;
  data_t               req_wdata;
  logic [MEM_BE_W-1:0] req_be;
  logic                rsp_valid;
  logic                rsp_ready;
  data_t               rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder_be_merge.sv
// Byte-lane merge of store data into an existing word.
module data_mem_responder_be_merge
  import data_mem_responder_pkg::*;
(
  input  data_t               old_word,
  input  data_t               wdata,
  input  logic [MEM_BE_W-1:0] be,
  output data_t               merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < MEM_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side load/store responder with programmable latency, byte enables and error response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned LATENCY  = 1
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned Depth   = MEM_SIZE / 4;
  localparam int unsigned AW      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [3:0]  LatInit = 4'(LATENCY);

  if (LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 0..15");
  end
  if ((MEM_SIZE % 4) != 0) begin : g_bad_size
    $error("MEM_SIZE must be a multiple of 4");
  end

  mem_rsp_state_t      state_q;
  logic [3:0]          cnt_q;
  addr_t               addr_q;
  logic                we_q;
  data_t               wdata_q;
  logic [MEM_BE_W-1:0] be_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  data_t               rdata_q;
  logic                err_q;

  data_t               mem [Depth];

  addr_t               acc_addr;
  logic                acc_we;
  data_t               acc_wdata;
  logic [MEM_BE_W-1:0] acc_be;
  logic                do_access;
  logic                acc_err;
  logic [AW-1:0]       acc_idx;
  data_t               old_word;
  data_t               merged;
  data_t               acc_rdata;

  // With zero latency the access uses the live request; otherwise the captured one.
  always_comb begin
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    do_access = 1'b0;
    if (state_q == StIdle) begin
      if (bus.req_valid && (LATENCY == 0)) begin
        do_access = 1'b1;
        acc_addr  = bus.req_addr;
        acc_we    = bus.req_we;
        acc_wdata = bus.req_wdata;
        acc_be    = bus.req_be;
      end
    end else if (state_q == StWait) begin
      do_access = (cnt_q == 4'd1);
    end
  end

  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr >= addr_t'(MEM_SIZE));
  assign acc_idx   = acc_addr[AW+1:2];
  assign old_word  = mem[acc_idx];
  assign acc_rdata = (acc_we || acc_err) ? '0 : old_word;

  data_mem_responder_be_merge u_be_merge (
    .old_word (old_word),
    .wdata    (acc_wdata),
    .be       (acc_be),
    .merged   (merged)
  );

  // Array is not reset; gating with reset keeps an access from landing while reset is held.
  always_ff @(posedge clk) begin
    if (reset && do_access && acc_we && !acc_err) begin
      mem[acc_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            we_q        <= bus.req_we;
            wdata_q     <= bus.req_wdata;
            be_q        <= bus.req_be;
            cnt_q       <= LatInit;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rdata_q     <= acc_rdata;
              err_q       <= acc_err;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rdata_q     <= acc_rdata;
            err_q       <= acc_err;
          end
          cnt_q <= cnt_q - 4'd1;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with three instances at latencies 0, 3 and 5.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_v [3];
  logic        req_we_v    [3];
  logic [31:0] req_addr_v  [3];
  logic [31:0] req_wdata_v [3];
  logic [3:0]  req_be_v    [3];
  logic        rsp_ready_v [3];
  logic        req_ready_v [3];
  logic        rsp_valid_v [3];
  logic [31:0] rsp_rdata_v [3];
  logic        rsp_err_v   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder_if bus ();
    assign bus.req_valid  = req_valid_v[g];
    assign bus.req_we     = req_we_v[g];
    assign bus.req_addr   = req_addr_v[g];
    assign bus.req_wdata  = req_wdata_v[g];
    assign bus.req_be     = req_be_v[g];
    assign bus.rsp_ready  = rsp_ready_v[g];
    assign req_ready_v[g] = bus.req_ready;
    assign rsp_valid_v[g] = bus.rsp_valid;
    assign rsp_rdata_v[g] = bus.rsp_rdata;
    assign rsp_err_v[g]   = bus.rsp_err;

    data_mem_responder #(
      .MEM_SIZE (1024),
      .LATENCY  ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  // One full transaction with rsp_ready high; lat = cycles from accept to first rsp_valid.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid_v[d] = 1'b1;
    req_we_v[d]    = we;
    req_addr_v[d]  = addr;
    req_wdata_v[d] = wdata;
    req_be_v[d]    = be;
    rsp_ready_v[d] = 1'b1;
    n = 0;
    while (!req_ready_v[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    rdata = 'x;
    err   = 1'bx;
    if (n >= 50) begin
      req_valid_v[d] = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1 req_valid_v[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid_v[d] && lat < 50);
    rdata = rsp_rdata_v[d];
    err   = rsp_err_v[d];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (req_ready_v[d] !== 1'b1) begin
        bad++; $display("FAIL reset_req_ready dut%0d got=%b want=1", d, req_ready_v[d]);
      end
      total++;
      if (rsp_valid_v[d] !== 1'b0) begin
        bad++; $display("FAIL reset_rsp_valid dut%0d got=%b want=0", d, rsp_valid_v[d]);
      end
      total++;
      if (rsp_rdata_v[d] !== 32'h0) begin
        bad++; $display("FAIL reset_rdata dut%0d got=%h want=0", d, rsp_rdata_v[d]);
      end
      total++;
      if (rsp_err_v[d] !== 1'b0) begin
        bad++; $display("FAIL reset_err dut%0d got=%b want=0", d, rsp_err_v[d]);
      end
    end
  endtask

  task automatic test_lat0_load();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    total++;
    if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL lat0_store lat=%0d rd=%h err=%b want lat=1 rd=0 err=0", lat, rd, er);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL lat0_load_latency got=%0d want=1", lat);
    end
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL lat0_load_data rd=%h err=%b want rd=deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_lat3_merge();
    logic [31:0] rd; logic er; int lat;
    txn(1, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, rd, er, lat);
    txn(1, 1'b1, 32'h20, 32'h11223344, 4'b0101, rd, er, lat);
    total++;
    if (lat !== 4 || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL lat3_store lat=%0d rd=%h err=%b want lat=4 rd=0 err=0", lat, rd, er);
    end
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (lat !== 4 || rd !== 32'hAA22AA44 || er !== 1'b0) begin
      bad++; $display("FAIL lat3_merge lat=%0d rd=%h err=%b want lat=4 rd=aa22aa44", lat, rd, er);
    end
    txn(1, 1'b1, 32'h20, 32'h55555555, 4'h0, rd, er, lat);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'hAA22AA44) begin
      bad++; $display("FAIL be_zero_noop got=%h want=aa22aa44", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
    txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL misaligned_load err=%b rd=%h want err=1 rd=0", er, rd);
    end
    txn(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL range_load err=%b rd=%h want err=1 rd=0", er, rd);
    end
    txn(0, 1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL misaligned_store err=%b rd=%h want err=1 rd=0", er, rd);
    end
    txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b1) begin
      bad++; $display("FAIL range_store err=%b want=1", er);
    end
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      bad++; $display("FAIL err_untouched_20 rd=%h err=%b want rd=12345678 err=0", rd, er);
    end
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      bad++; $display("FAIL err_untouched_0 rd=%h err=%b want rd=0badf00d err=0", rd, er);
    end
    txn(0, 1'b1, 32'h3FC, 32'hC0FFEE11, 4'hF, rd, er, lat);
    txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'hC0FFEE11 || er !== 1'b0) begin
      bad++; $display("FAIL last_word rd=%h err=%b want rd=c0ffee11 err=0", rd, er);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] rd; logic er; int lat; int n;
    txn(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, er, lat);
    @(negedge clk);
    rsp_ready_v[1] = 1'b0;
    req_valid_v[1] = 1'b1;
    req_we_v[1]    = 1'b0;
    req_addr_v[1]  = 32'h30;
    req_be_v[1]    = 4'h0;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid_v[1] && n < 50);
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL bp_first_latency got=%0d want=4", n);
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid_v[1] !== 1'b1 || rsp_rdata_v[1] !== 32'hCAFEF00D || rsp_err_v[1] !== 1'b0
          || req_ready_v[1] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold c=%0d valid=%b rd=%h err=%b ready=%b want 1/cafef00d/0/0",
                 c, rsp_valid_v[1], rsp_rdata_v[1], rsp_err_v[1], req_ready_v[1]);
      end
      @(negedge clk);
    end
    rsp_ready_v[1] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready_v[1] !== 1'b1 || rsp_valid_v[1] !== 1'b0) begin
      bad++; $display("FAIL bp_after_handshake ready=%b valid=%b want 1/0",
                      req_ready_v[1], rsp_valid_v[1]);
    end
    @(posedge clk);
    #1 req_valid_v[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid_v[1] && n < 50);
    total++;
    if (n !== 4 || rsp_rdata_v[1] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL bp_second lat=%0d rd=%h want lat=4 rd=cafef00d", n, rsp_rdata_v[1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    txn(2, 1'b1, 32'h40, 32'h01020304, 4'hF, rd, er, lat);
    total++;
    if (lat !== 6) begin
      bad++; $display("FAIL lat5_latency got=%0d want=6", lat);
    end
    @(negedge clk);
    req_valid_v[2] = 1'b1;
    req_we_v[2]    = 1'b1;
    req_addr_v[2]  = 32'h40;
    req_wdata_v[2] = 32'hFFFFFFFF;
    req_be_v[2]    = 4'hF;
    @(posedge clk);
    #1 req_valid_v[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (rsp_valid_v[2] !== 1'b0 || req_ready_v[2] !== 1'b1) begin
      bad++; $display("FAIL reset_async valid=%b ready=%b want 0/1", rsp_valid_v[2], req_ready_v[2]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid_v[2] !== 1'b0 || req_ready_v[2] !== 1'b1) begin
      bad++; $display("FAIL reset_release valid=%b ready=%b want 0/1", rsp_valid_v[2], req_ready_v[2]);
    end
    txn(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'h01020304 || er !== 1'b0) begin
      bad++; $display("FAIL store_discarded rd=%h err=%b want rd=01020304 err=0", rd, er);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid_v[d] = 1'b0;
      req_we_v[d]    = 1'b0;
      req_addr_v[d]  = '0;
      req_wdata_v[d] = '0;
      req_be_v[d]    = '0;
      rsp_ready_v[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_lat0_load();
    test_lat3_merge();
    test_errors();
    test_back_pressure();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
